m_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the execute stage. It generates sequential instruction addresses, issues them to an instruction memory with a request/ready handshake, and buffers returned words with their PCs in a small in-order prefetch FIFO. It delivers {pc, instruction} pairs to the execute stage over a valid/ready handshake. A redirect input, driven by execute on a taken branch or jump, flushes all buffered and in-flight fetches.

---
 rtl/m_fetch.sv | 96 +++++++++
 tb/tb_m_fetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m_fetch.sv
// rtl/m_fetch.sv - instruction fetch stage: sequential PC generation, in-order prefetch FIFO, redirect flush
module m_fetch #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        w_clk,
   input  logic        w_rst,
   output logic        w_imem_req,
   output logic [31:0] w_imem_addr,
   input  logic        w_imem_ready,
   input  logic        w_imem_rvalid,
   input  logic [31:0] w_imem_rdata,
   input  logic        w_redirect,
   input  logic [31:0] w_redirect_pc,
   output logic        w_inst_valid,
   output logic [31:0] w_inst,
   output logic [31:0] w_inst_pc,
   input  logic        w_inst_ready
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned PW = CW + 1;
   // Drop backlog is not bounded by the credit rule; back-to-back redirects can stack it past DEPTH.
   localparam int unsigned DW = 16;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_fifo_pc   [DEPTH];
   logic [31:0]   r_fifo_inst [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outstanding;
   logic [DW-1:0] r_drop;

   logic          w_accept;
   logic          w_pop;
   logic          w_push;
   logic          w_resp_owed;
   logic [PW-1:0] w_credit_used;
   logic [31:0]   w_resp_pc;
   logic [31:0]   w_restart_pc;

   assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_imem_req    = !w_rst && !w_redirect && (w_credit_used < PW'(DEPTH));
   assign w_imem_addr   = r_fetch_pc;
   assign w_accept      = w_imem_req && w_imem_ready;
   assign w_pop         = w_inst_valid && w_inst_ready;
   assign w_resp_owed   = (r_drop != '0) || (r_outstanding != '0);
   assign w_push        = w_imem_rvalid && !w_redirect && (r_drop == '0) && (r_outstanding != '0);
   assign w_restart_pc  = w_redirect_pc & 32'hFFFF_FFFC;

   // Addresses since the last redirect are consecutive, so the oldest outstanding PC is
   // recovered from the fetch PC instead of being stored in a separate tag queue.
   assign w_resp_pc = r_fetch_pc - {{(30-CW){1'b0}}, r_outstanding, 2'b00};

   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_fetch_pc    <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
      end else if (w_redirect) begin
         r_fetch_pc    <= w_restart_pc;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= r_drop + DW'(r_outstanding)
                          - ((w_imem_rvalid && w_resp_owed) ? DW'(1) : DW'(0));
      end else begin
         if (w_accept)
            r_fetch_pc <= r_fetch_pc + 32'd4;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         r_count       <= r_count + CW'(w_push) - CW'(w_pop);
         r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_push);
         if (w_imem_rvalid && (r_drop != '0))
            r_drop <= r_drop - DW'(1);
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]   <= w_resp_pc;
         r_fifo_inst[r_wr_ptr] <= w_imem_rdata;
      end
   end

   assign w_inst_valid = (r_count != '0);
   assign w_inst       = w_inst_valid ? r_fifo_inst[r_rd_ptr] : 32'h0;
   assign w_inst_pc    = w_inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;
endmodule

// File: tb/tb_m_fetch.sv
// tb/tb_m_fetch.sv - directed bench for m_fetch with an in-order variable-latency memory model
module tb_m_fetch;
   logic        w_clk = 1'b0;
   logic        w_rst;
   logic        w_imem_req;
   logic [31:0] w_imem_addr;
   logic        w_imem_ready;
   logic        w_imem_rvalid;
   logic [31:0] w_imem_rdata;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;
   logic        w_inst_valid;
   logic [31:0] w_inst;
   logic [31:0] w_inst_pc;
   logic        w_inst_ready;

   m_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
      .w_clk(w_clk), .w_rst(w_rst),
      .w_imem_req(w_imem_req), .w_imem_addr(w_imem_addr), .w_imem_ready(w_imem_ready),
      .w_imem_rvalid(w_imem_rvalid), .w_imem_rdata(w_imem_rdata),
      .w_redirect(w_redirect), .w_redirect_pc(w_redirect_pc),
      .w_inst_valid(w_inst_valid), .w_inst(w_inst), .w_inst_pc(w_inst_pc),
      .w_inst_ready(w_inst_ready)
   );

   always #5 w_clk = ~w_clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int lat   = 1;
   int n_acc = 0;
   logic [31:0] last_acc;
   logic        last_req;

   logic [31:0] mq_addr[$];
   int          mq_due[$];
   logic [31:0] dq_pc[$];
   logic [31:0] dq_inst[$];
   int          dq_cyc[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] dpc(input int i);
      return (i >= 0 && i < dq_pc.size()) ? dq_pc[i] : 32'hDEADBEEF;
   endfunction
   function automatic logic [31:0] dinst(input int i);
      return (i >= 0 && i < dq_inst.size()) ? dq_inst[i] : 32'hDEADBEEF;
   endfunction
   function automatic logic [31:0] dcyc(input int i);
      return (i >= 0 && i < dq_cyc.size()) ? 32'(dq_cyc[i]) : 32'hDEADBEEF;
   endfunction

   // One clock cycle: present memory response, record accept/delivery, cross the edge.
   task automatic tick();
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         w_imem_rvalid = 1'b1;
         w_imem_rdata  = mq_addr[0];
      end else begin
         w_imem_rvalid = 1'b0;
         w_imem_rdata  = 32'h0;
      end
      #1;
      last_req = w_imem_req;
      if (w_imem_rvalid) begin
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end
      if (w_imem_req && w_imem_ready) begin
         mq_addr.push_back(w_imem_addr);
         mq_due.push_back(cyc + lat);
         n_acc++;
         last_acc = w_imem_addr;
      end
      if (w_inst_valid && w_inst_ready) begin
         dq_pc.push_back(w_inst_pc);
         dq_inst.push_back(w_inst);
         dq_cyc.push_back(cyc);
      end
      @(posedge w_clk);
      cyc++;
      @(negedge w_clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_log();
      dq_pc.delete();
      dq_inst.delete();
      dq_cyc.delete();
   endtask

   task automatic do_reset();
      w_rst = 1'b1;
      w_redirect = 1'b0;
      w_redirect_pc = 32'h0;
      w_imem_ready = 1'b0;
      w_inst_ready = 1'b0;
      tick();
      mq_addr.delete();
      mq_due.delete();
      clear_log();
      n_acc = 0;
      w_rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      int stale;
      int k;
      w_rst = 1'b1;
      w_redirect = 1'b0;
      w_redirect_pc = 32'h0;
      w_imem_ready = 1'b0;
      w_imem_rvalid = 1'b0;
      w_imem_rdata = 32'h0;
      w_inst_ready = 1'b0;
      @(negedge w_clk);

      check("rst_req", 32'(w_imem_req), 32'h0);
      check("rst_addr", w_imem_addr, 32'h0);
      check("rst_valid", 32'(w_inst_valid), 32'h0);
      check("rst_inst", w_inst, 32'h0);
      check("rst_pc", w_inst_pc, 32'h0);

      // Streaming, 1-cycle memory: one instruction per cycle from cycle 2.
      do_reset();
      lat = 1; w_imem_ready = 1'b1; w_inst_ready = 1'b1;
      ticks(10);
      check("t1_count", 32'(dq_pc.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("t1_pc", dpc(i), 32'(4 * i));
         check("t1_inst", dinst(i), 32'(4 * i));
         check("t1_cyc", dcyc(i), 32'(2 + i));
      end

      // Backpressure: exactly four requests then credit stall.
      do_reset();
      lat = 1; w_imem_ready = 1'b1; w_inst_ready = 1'b0;
      ticks(6);
      check("t2_stall_pc", w_inst_pc, 32'h0);
      ticks(2);
      check("t2_nacc", 32'(n_acc), 32'd4);
      check("t2_last_addr", last_acc, 32'hC);
      check("t2_req_off", 32'(w_imem_req), 32'h0);
      check("t2_valid", 32'(w_inst_valid), 32'h1);
      check("t2_stall_inst", w_inst, 32'h0);
      w_inst_ready = 1'b1;
      ticks(10);
      for (int i = 0; i < 5; i++)
         check("t2_pc", dpc(i), 32'(4 * i));

      // 3-cycle memory, redirect with two outstanding requests.
      do_reset();
      lat = 3; w_imem_ready = 1'b1; w_inst_ready = 1'b1;
      ticks(2);
      w_redirect = 1'b1; w_redirect_pc = 32'h103;
      tick();
      w_redirect = 1'b0;
      check("t3_req_in_redirect", 32'(last_req), 32'h0);
      check("t3_drop", 32'(dut.r_drop), 32'd2);
      ticks(12);
      check("t3_first_pc", dpc(0), 32'h100);
      check("t3_first_inst", dinst(0), 32'h100);
      check("t3_second_pc", dpc(1), 32'h104);
      stale = 0;
      foreach (dq_pc[i]) if (dq_pc[i] < 32'h100) stale++;
      check("t3_stale", 32'(stale), 32'h0);

      // Redirect coinciding with rvalid and pop, 2-cycle memory.
      do_reset();
      lat = 2; w_imem_ready = 1'b1; w_inst_ready = 1'b1;
      ticks(3);
      w_redirect = 1'b1; w_redirect_pc = 32'h200;
      tick();
      w_redirect = 1'b0;
      check("t4_delivered_n", 32'(dq_pc.size()), 32'd1);
      check("t4_delivered_pc", dpc(0), 32'h0);
      check("t4_drop", 32'(dut.r_drop), 32'd1);
      ticks(8);
      check("t4_next_pc", dpc(1), 32'h200);
      check("t4_next_inst", dinst(1), 32'h200);

      // Redirect near the top of the address space wraps to zero.
      do_reset();
      lat = 1; w_imem_ready = 1'b1; w_inst_ready = 1'b1;
      ticks(4);
      w_redirect = 1'b1; w_redirect_pc = 32'hFFFF_FFF8;
      tick();
      w_redirect = 1'b0;
      ticks(10);
      k = -1;
      for (int i = 0; i < dq_cyc.size(); i++)
         if (k < 0 && dq_cyc[i] > 4) k = i;
      check("t5_latency", dcyc(k), 32'd7);
      check("t5_pc0", dpc(k), 32'hFFFF_FFF8);
      check("t5_pc1", dpc(k + 1), 32'hFFFF_FFFC);
      check("t5_pc2", dpc(k + 2), 32'h0);
      check("t5_pc3", dpc(k + 3), 32'h4);
      check("t5_inst1", dinst(k + 1), 32'hFFFF_FFFC);

      // Asynchronous reset with FIFO half full and responses still in flight.
      do_reset();
      lat = 3; w_imem_ready = 1'b1; w_inst_ready = 1'b0;
      ticks(5);
      check("t6_count_before", 32'(dut.r_count), 32'd2);
      w_rst = 1'b1;
      #1;
      check("t6_valid_async", 32'(w_inst_valid), 32'h0);
      check("t6_req_async", 32'(w_imem_req), 32'h0);
      check("t6_addr_async", w_imem_addr, 32'h0);
      tick();
      w_rst = 1'b0; w_imem_ready = 1'b0;
      clear_log();
      tick();
      check("t6_late_ignored", 32'(w_inst_valid), 32'h0);
      w_imem_ready = 1'b1; w_inst_ready = 1'b1;
      ticks(8);
      check("t6_first_pc", dpc(0), 32'h0);
      check("t6_first_inst", dinst(0), 32'h0);
      check("t6_second_pc", dpc(1), 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
